// File: rtl/msg_arbiter_framer_pkg.sv
// Shared constants for the message arbiter/framer: default parameters, FSM encoding
// and the source-index width helper.
package msg_arbiter_framer_pkg;

  localparam int         NUM_SOURCES_DEF = 4;
  localparam logic [7:0] START_BYTE_DEF  = 8'hAA;
  localparam logic [7:0] CRC_POLY_DEF    = 8'h07;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_LEN     = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_CRC     = 3'd5;

  // A single source still needs a one-bit index.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msg_arbiter_framer_crc8_byte.sv
// One-byte CRC-8 step, MSB first, no reflection; shared with the decoder-side checker.
module crc8_byte
  import msg_arbiter_framer_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[7] ? ((crc_out << 1) ^ CRC_POLY) : (crc_out << 1);
    end
  end

endmodule

// File: rtl/msg_arbiter_framer.sv
// Arbitrates between message sources and emits START/ADDR/LEN/payload/CRC frames
// as an AXI-stream byte flow towards the UART transmitter.
module msg_arbiter_framer
  import msg_arbiter_framer_pkg::*;
#(
  parameter int         NUM_SOURCES = NUM_SOURCES_DEF,
  parameter bit         RR_MODE     = 1'b1,
  parameter logic [7:0] START_BYTE  = START_BYTE_DEF,
  parameter logic [7:0] CRC_POLY    = CRC_POLY_DEF,
  localparam int        SRC_W       = src_w(NUM_SOURCES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SOURCES-1:0]   have_msg_bus,
  input  logic [8*NUM_SOURCES-1:0] len_bus,
  input  logic [8*NUM_SOURCES-1:0] data_bus,
  output logic [NUM_SOURCES-1:0]   rdreq_bus,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [SRC_W-1:0]         cur_src,
  output logic                     frame_done
);

  logic [2:0]       state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_any;
  logic [SRC_W:0]   rr_sum;
  logic [7:0]       len_q;
  logic [7:0]       cnt;
  logic [7:0]       crc_q;
  logic [7:0]       crc_next;
  logic [7:0]       addr_byte;
  logic             accept;

  assign tx_valid = (state != S_IDLE);
  assign accept   = tx_valid && tx_ready;

  // Candidates are scanned from lowest to highest priority so the last hit wins.
  always_comb begin
    grant_any = |have_msg_bus;
    grant_idx = '0;
    rr_sum    = '0;
    if (RR_MODE) begin
      for (int k = NUM_SOURCES; k >= 1; k--) begin
        rr_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
        if (rr_sum >= (SRC_W+1)'(NUM_SOURCES)) begin
          rr_sum = rr_sum - (SRC_W+1)'(NUM_SOURCES);
        end
        if (have_msg_bus[rr_sum[SRC_W-1:0]]) begin
          grant_idx = rr_sum[SRC_W-1:0];
        end
      end
    end else begin
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
        if (have_msg_bus[i]) begin
          grant_idx = SRC_W'(i);
        end
      end
    end
  end

  always_comb begin
    addr_byte = '0;
    addr_byte[SRC_W-1:0] = cur_src;
  end

  always_comb begin
    case (state)
      S_START:   tx_data = START_BYTE;
      S_ADDR:    tx_data = addr_byte;
      S_LEN:     tx_data = len_q;
      S_PAYLOAD: tx_data = data_bus[{cur_src, 3'b000} +: 8];
      S_CRC:     tx_data = crc_q;
      default:   tx_data = 8'h00;
    endcase
  end

  always_comb begin
    rdreq_bus = '0;
    if (state == S_PAYLOAD && tx_ready) begin
      rdreq_bus[cur_src] = 1'b1;
    end
  end

  crc8_byte #(.CRC_POLY(CRC_POLY)) u_crc (
    .crc_in  (crc_q),
    .data    (tx_data),
    .crc_out (crc_next)
  );

  // Frame sequencer: one state per emitted field, advancing only on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      cur_src    <= '0;
      frame_done <= 1'b0;
      crc_q      <= 8'h00;
      cnt        <= 8'h00;
      rr_ptr     <= SRC_W'(NUM_SOURCES - 1);
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            state   <= S_START;
            cur_src <= grant_idx;
            rr_ptr  <= grant_idx;
            busy    <= 1'b1;
            cnt     <= 8'h00;
          end
        end
        S_START: if (accept) state <= S_ADDR;
        S_ADDR: begin
          if (accept) begin
            state <= S_LEN;
            crc_q <= crc_next;
          end
        end
        S_LEN: begin
          if (accept) begin
            crc_q <= crc_next;
            state <= (len_q == 8'h00) ? S_CRC : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            crc_q <= crc_next;
            cnt   <= cnt + 8'h01;
            if (cnt == len_q - 8'h01) state <= S_CRC;
          end
        end
        S_CRC: begin
          if (accept) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            crc_q      <= 8'h00;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Length is datapath: captured at grant, never needs a reset value.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && grant_any) begin
      len_q <= len_bus[{grant_idx, 3'b000} +: 8];
    end
  end

endmodule

// File: doc/msg_arbiter_framer.md
Name: msg_arbiter_framer

Overview:
Parametrised successor to the single-stream message encoder feeding the RS-485 UART transmitter. Arbitrates among NUM_SOURCES peripheral message queues (SPI ADC, DDS, voltage-source DAC, ...), selectable round-robin or fixed priority. Wraps each granted message into a framed, CRC-protected packet on an AXI-stream byte output to the UART core. Sits between the per-interface queues and uart.input_axis_*.

Parameters:
NUM_SOURCES, 4, number of message sources; 1..256.
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
START_BYTE, 8'hAA, frame start marker.
CRC_POLY, 8'h07, CRC-8 polynomial; init 8'h00, MSB-first, no reflection, no final XOR.

Ports:
clk  in  1  system clock (fpga_clk_48 at top level)
rst  in  1  synchronous reset, active-high
have_msg_bus  in  NUM_SOURCES  bit i: source i holds a complete message
len_bus  in  8*NUM_SOURCES  byte i: payload length of source i; valid while have_msg_bus[i]
data_bus  in  8*NUM_SOURCES  byte i: show-ahead head byte of source i queue
rdreq_bus  out  NUM_SOURCES  one-cycle pop strobe per source
tx_data  out  8  AXI-stream byte to UART
tx_valid  out  1  AXI-stream valid
tx_ready  in  1  AXI-stream ready
busy  out  1  high from grant until CRC byte accepted
cur_src  out  max(1,$clog2(NUM_SOURCES))  index of granted source
frame_done  out  1  one-cycle pulse when CRC byte accepted

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high (rst).
- Reset values: tx_valid=0, tx_data=0, rdreq_bus=0, busy=0, cur_src=0, frame_done=0, state=IDLE, CRC=0, RR pointer=NUM_SOURCES-1, so source 0 wins first.
- Frame format: START_BYTE, ADDR (cur_src zero-extended to 8 bits), LEN, LEN payload bytes, CRC. CRC covers ADDR, LEN and payload; START is excluded.
- States: IDLE -> START -> ADDR -> LEN -> (PAYLOAD if LEN!=0) -> CRC -> IDLE.
- IDLE: if any have_msg_bus bit is set at edge N, register grant, cur_src, LEN latch and busy=1. tx_valid=1 with START_BYTE from cycle N+1.
- Byte advance: only on tx_valid && tx_ready. tx_data is stable while tx_valid && !tx_ready. tx_valid never drops mid-frame except on rst.
- PAYLOAD: tx_data = data_bus[cur_src] combinationally. rdreq_bus[cur_src] = tx_valid && tx_ready in PAYLOAD. Only one rdreq bit high at a time, exactly LEN pulses per frame. A byte counter, 8 bits, counts to LEN and moves to CRC after the LEN-th accept.
- LEN=0: LEN -> CRC directly; no rdreq issued.
- CRC: the CRC byte is the final register value. On accept: frame_done=1 for one cycle, busy=0, CRC cleared, state IDLE. A new grant may be registered in that same IDLE cycle, giving a minimum one-cycle tx_valid gap between frames.
- Round-robin: search starts at last_grant+1, modulo NUM_SOURCES. The pointer updates at grant. Fixed priority: lowest set index.
- have_msg_bus and len_bus are ignored after grant. A de-assertion mid-frame does not abort; LEN is the latched value.
- A source asserting have_msg while another is mid-frame waits; no preemption.
- Sources guarantee LEN bytes are queued. No underflow check.
- rst mid-frame: abort at that edge. tx_valid=0 and no rdreq from the next cycle. The partial frame is discarded by the host on CRC/START resync.

Decomposition:
- Shared package/defines: NUM_SOURCES, START_BYTE, CRC_POLY, state encoding localparams, SRC_W width function.
- Sub-module crc8_byte: combinational, crc_in[7:0] + data[7:0] -> crc_out[7:0], parametrised by CRC_POLY. Also reused by the decoder-side checker.
- Arbiter logic stays inline.

Test Plan:
- crc8_byte standalone: feed ASCII "123456789" sequentially from 0x00 -> final 8'hF4.
- Single source 0, LEN=2, payload 11,22, tx_ready=1 -> bytes AA 00 02 11 22 CRC (CRC = crc8_byte chain over 00 02 11 22). Exactly 2 rdreq_bus[0] pulses, coincident with the 11/22 accepts. frame_done once. busy high for 6 accepts.
- Backpressure: same frame, tx_ready toggled randomly and held low 5 cycles during payload -> tx_data/tx_valid stable while stalled, no rdreq while tx_ready=0, identical byte sequence.
- RR_MODE=1, sources 0 and 2 permanently pending (LEN=1) -> ADDR sequence 00,02,00,02. RR_MODE=0, same stimulus -> 00,00,00.
- LEN=0 on source 3 -> AA 03 00 CRC, zero rdreq pulses. Source 1 dropping have_msg mid-frame -> frame still completes with the latched LEN.
- rst asserted during the 2nd payload byte of a LEN=4 frame -> next cycle tx_valid=0, rdreq_bus=0, busy=0. After release, the pending source is re-framed from START with round-robin order restarting at source 0.
